// File: rtl/axi_slave_r_pop_fsm_pkg.sv
// Shared types and constants for the AXI slave R-channel pop side.
// State encoding, RRESP codes and boolean helpers.
package axi_slave_package;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/axi_slave_r_pop_fsm_r_beat_down_counter.sv
// Remaining-beat counter for one read burst.
// Load wins over decrement; decrement stops at zero.
module r_beat_down_counter
  import axi_slave_package::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         is_zero
);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !is_zero) begin
      count <= count - 1'b1;
    end
  end

  assign is_zero = (count == '0) ? TRUE : FALSE;

endmodule

// File: rtl/axi_slave_r_pop_fsm.sv
// Drains descriptor and data FIFOs onto the AXI R channel.
// Counts beats from ARLEN, drives RLAST, chains bursts without bubbles.
module axi_slave_r_pop_fsm
  import axi_slave_package::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  desc_empty,
  input  logic [ID_WIDTH-1:0]   desc_id,
  input  logic [LEN_WIDTH-1:0]  desc_len,
  input  logic [1:0]            desc_resp,
  output logic                  desc_rd_en,
  input  logic                  data_empty,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  data_rd_en,
  output logic [ID_WIDTH-1:0]   RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  busy
);

  state_t                state;
  logic [ID_WIDTH-1:0]   id_q;
  logic [1:0]            resp_q;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic                  cnt_zero;
  logic                  in_send;
  logic                  hs;
  logic                  last_hs;
  logic                  load;

  assign in_send = (state == SEND);
  assign RVALID  = in_send && !data_empty;
  assign hs      = RVALID && RREADY;
  assign last_hs = hs && cnt_zero;

  // A descriptor is taken from IDLE, or chained on the final beat.
  always_comb begin
    load = FALSE;
    unique case (state)
      IDLE: load = !desc_empty;
      SEND: load = last_hs && !desc_empty;
      default: load = FALSE;
    endcase
  end

  assign desc_rd_en = load;
  assign data_rd_en = hs;
  assign busy       = in_send;
  assign RLAST      = RVALID && cnt_zero;
  assign RDATA      = RVALID ? data_in : '0;
  assign RID        = in_send ? id_q : '0;
  assign RRESP      = in_send ? resp_q : OKAY;

  r_beat_down_counter #(
    .W(LEN_WIDTH)
  ) u_cnt (
    .clk     (clk),
    .arst    (arst),
    .load    (load),
    .load_val(desc_len),
    .dec     (hs),
    .count   (beat_cnt),
    .is_zero (cnt_zero)
  );

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state  <= IDLE;
      id_q   <= '0;
      resp_q <= OKAY;
    end else begin
      unique case (state)
        IDLE: begin
          if (!desc_empty) begin
            id_q   <= desc_id;
            resp_q <= desc_resp;
            state  <= SEND;
          end
        end
        SEND: begin
          if (last_hs) begin
            if (!desc_empty) begin
              id_q   <= desc_id;
              resp_q <= desc_resp;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
